// File: rtl/ethsim_pkg.sv
// ethsim_pkg: routing-mode constants, keep-width helper and the default-width
// beat type shared by the ethsim bridge and its lanes.
package ethsim_pkg;

    localparam int unsigned MODE_LOOP     = 0;
    localparam int unsigned MODE_SWAP     = 1;
    localparam int unsigned ETHSIM_DATA_W = 64;

    function automatic int unsigned keep_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic                         user;
        logic                         last;
        logic [ETHSIM_DATA_W/8-1:0]   keep;
        logic [ETHSIM_DATA_W-1:0]     data;
    } beat_t;

endpackage

// File: rtl/ethsim_lane_fifo.sv
// ethsim_lane_fifo: one DEPTH-entry synchronous FIFO carrying a whole
// AXI-Stream beat; ready and valid depend only on the registered count.
module ethsim_lane_fifo
    import ethsim_pkg::*;
#(
    parameter int unsigned  DATA_W = 64,
    parameter int unsigned  DEPTH  = 8,
    localparam int unsigned KEEP_W = keep_w(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [KEEP_W-1:0] i_in_keep,
    input  logic              i_in_last,
    input  logic              i_in_user,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [KEEP_W-1:0] o_out_keep,
    output logic              o_out_last,
    output logic              o_out_user
);

    localparam int unsigned   AW         = $clog2(DEPTH);
    localparam int unsigned   CW         = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic              user;
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } lane_beat_t;

    lane_beat_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic       w_valid;
    lane_beat_t w_head;

    // Ready is gated by reset so no beat is taken while lanes are being flushed.
    assign o_in_ready = !i_rst && (r_count < FULL_COUNT);
    assign w_valid    = (r_count != '0);
    assign w_push     = i_in_valid && o_in_ready;
    assign w_pop      = w_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_user, i_in_last, i_in_keep, i_in_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs read zero while empty so the reset/idle tx bus is all-zero.
    assign w_head      = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_out_valid = w_valid;
    assign o_out_data  = w_head.data;
    assign o_out_keep  = w_head.keep;
    assign o_out_last  = w_head.last;
    assign o_out_user  = w_head.user;

endmodule

// File: rtl/ethsim_xbar_bridge.sv
// ethsim_xbar_bridge: N-port AXI-Stream bridge, one FIFO lane per rx port routed
// to tx by MODE. Defining ETHSIM_BRIDGE_STATS_EN adds per-port frame/error counters.
module ethsim_xbar_bridge
    import ethsim_pkg::*;
#(
    parameter int unsigned  NPORTS = 4,
    parameter int unsigned  DATA_W = 64,
    parameter int unsigned  DEPTH  = 8,
    parameter int unsigned  MODE   = MODE_LOOP,
    localparam int unsigned KEEP_W = keep_w(DATA_W)
) (
    input  logic                     clk156,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        rx_tvalid,
    input  logic [NPORTS*DATA_W-1:0] rx_tdata,
    input  logic [NPORTS*KEEP_W-1:0] rx_tkeep,
    input  logic [NPORTS-1:0]        rx_tlast,
    input  logic [NPORTS-1:0]        rx_tuser,
    output logic [NPORTS-1:0]        rx_tready,
    input  logic [NPORTS-1:0]        tx_tready,
    output logic [NPORTS-1:0]        tx_tvalid,
    output logic [NPORTS*DATA_W-1:0] tx_tdata,
    output logic [NPORTS*KEEP_W-1:0] tx_tkeep,
    output logic [NPORTS-1:0]        tx_tlast,
    output logic [NPORTS-1:0]        tx_tuser
`ifdef ETHSIM_BRIDGE_STATS_EN
    ,
    output logic [NPORTS*32-1:0]     stat_frames,
    output logic [NPORTS*32-1:0]     stat_errs
`endif
);

    for (genvar j = 0; j < NPORTS; j++) begin : g_lane
        // Lane j always sits behind rx port j; only its tx side moves with MODE.
        localparam int unsigned DST = (MODE == MODE_SWAP) ? (j ^ 1) : j;

        ethsim_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .i_clk       (clk156),
            .i_rst       (rst),
            .i_in_valid  (rx_tvalid[j]),
            .o_in_ready  (rx_tready[j]),
            .i_in_data   (rx_tdata[j*DATA_W +: DATA_W]),
            .i_in_keep   (rx_tkeep[j*KEEP_W +: KEEP_W]),
            .i_in_last   (rx_tlast[j]),
            .i_in_user   (rx_tuser[j]),
            .o_out_valid (tx_tvalid[DST]),
            .i_out_ready (tx_tready[DST]),
            .o_out_data  (tx_tdata[DST*DATA_W +: DATA_W]),
            .o_out_keep  (tx_tkeep[DST*KEEP_W +: KEEP_W]),
            .o_out_last  (tx_tlast[DST]),
            .o_out_user  (tx_tuser[DST])
        );
    end

`ifdef ETHSIM_BRIDGE_STATS_EN
    for (genvar j = 0; j < NPORTS; j++) begin : g_stat
        logic        w_acc_last;
        logic [31:0] r_frames;
        logic [31:0] r_errs;

        assign w_acc_last = rx_tvalid[j] && rx_tready[j] && rx_tlast[j];

        always_ff @(posedge clk156) begin
            if (rst) begin
                r_frames <= '0;
                r_errs   <= '0;
            end else if (w_acc_last) begin
                r_frames <= r_frames + 32'd1;
                if (rx_tuser[j]) begin
                    r_errs <= r_errs + 32'd1;
                end
            end
        end

        assign stat_frames[j*32 +: 32] = r_frames;
        assign stat_errs[j*32 +: 32]   = r_errs;
    end
`endif

endmodule

// File: tb/tb_ethsim_xbar_bridge.sv
// Scoreboard bench for ethsim_xbar_bridge: a loopback and a pair-swap instance,
// each checked against per-tx-port queues of expected beats.
`timescale 1ns/1ps
module tb_ethsim_xbar_bridge;
    import ethsim_pkg::*;

    localparam int unsigned NPORTS = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NL     = 2 * NPORTS;

    logic clk156 = 1'b0;
    logic rst;
    always #5 clk156 = ~clk156;

    logic [NPORTS-1:0]        rxv [2];
    logic [NPORTS-1:0]        rxl [2];
    logic [NPORTS-1:0]        rxu [2];
    logic [NPORTS-1:0]        rxr [2];
    logic [NPORTS-1:0]        txr [2];
    logic [NPORTS-1:0]        txv [2];
    logic [NPORTS-1:0]        txl [2];
    logic [NPORTS-1:0]        txu [2];
    logic [NPORTS*DATA_W-1:0] rxd [2];
    logic [NPORTS*DATA_W-1:0] txd [2];
    logic [NPORTS*KEEP_W-1:0] rxk [2];
    logic [NPORTS*KEEP_W-1:0] txk [2];
`ifdef ETHSIM_BRIDGE_STATS_EN
    logic [NPORTS*32-1:0]     sf  [2];
    logic [NPORTS*32-1:0]     se  [2];
    logic [31:0]              m_frames [NL];
    logic [31:0]              m_errs   [NL];
`endif

    ethsim_xbar_bridge #(.NPORTS(NPORTS), .DATA_W(DATA_W), .DEPTH(DEPTH), .MODE(MODE_LOOP)) u_loop (
        .clk156(clk156), .rst(rst),
        .rx_tvalid(rxv[0]), .rx_tdata(rxd[0]), .rx_tkeep(rxk[0]), .rx_tlast(rxl[0]),
        .rx_tuser(rxu[0]), .rx_tready(rxr[0]), .tx_tready(txr[0]), .tx_tvalid(txv[0]),
        .tx_tdata(txd[0]), .tx_tkeep(txk[0]), .tx_tlast(txl[0]), .tx_tuser(txu[0])
`ifdef ETHSIM_BRIDGE_STATS_EN
        , .stat_frames(sf[0]), .stat_errs(se[0])
`endif
    );

    ethsim_xbar_bridge #(.NPORTS(NPORTS), .DATA_W(DATA_W), .DEPTH(DEPTH), .MODE(MODE_SWAP)) u_swap (
        .clk156(clk156), .rst(rst),
        .rx_tvalid(rxv[1]), .rx_tdata(rxd[1]), .rx_tkeep(rxk[1]), .rx_tlast(rxl[1]),
        .rx_tuser(rxu[1]), .rx_tready(rxr[1]), .tx_tready(txr[1]), .tx_tvalid(txv[1]),
        .tx_tdata(txd[1]), .tx_tkeep(txk[1]), .tx_tlast(txl[1]), .tx_tuser(txu[1])
`ifdef ETHSIM_BRIDGE_STATS_EN
        , .stat_frames(sf[1]), .stat_errs(se[1])
`endif
    );

    // Index k = inst*NPORTS + port for all per-lane model state.
    beat_t             sb  [NL][$];   // expected beats per tx port, oldest first
    beat_t             src [NL][$];   // beats still to be offered per rx port
    bit                acc [NL];
    logic              exp_rdy [NL];
    logic [NPORTS-1:0] hold_lo [2];
    int unsigned       vprob;
    int unsigned       rprob;
    int unsigned       checks   = 0;
    int unsigned       failures = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dst(input int i, input int j);
        return (i == 1) ? (j ^ 1) : j;
    endfunction

    function automatic beat_t rx_beat(input int i, input int j);
        return {rxu[i][j], rxl[i][j], rxk[i][j*KEEP_W +: KEEP_W], rxd[i][j*DATA_W +: DATA_W]};
    endfunction

    function automatic beat_t tx_beat(input int i, input int j);
        return {txu[i][j], txl[i][j], txk[i][j*KEEP_W +: KEEP_W], txd[i][j*DATA_W +: DATA_W]};
    endfunction

    function automatic bit idle();
        for (int k = 0; k < NL; k++) begin
            if (src[k].size() != 0 || sb[k].size() != 0) return 1'b0;
        end
        return (rxv[0] == '0) && (rxv[1] == '0);
    endfunction

    // Acceptance side: occupancy-based ready/valid expectations, then record accepted beats.
    always @(negedge clk156) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < NPORTS; j++) begin
                exp_rdy[i*NPORTS+j] = !rst && (sb[i*NPORTS+dst(i, j)].size() < DEPTH);
                chk(rxr[i][j] === exp_rdy[i*NPORTS+j], $sformatf("i%0d p%0d rx_tready", i, j),
                    128'(rxr[i][j]), 128'(exp_rdy[i*NPORTS+j]));
                chk(txv[i][j] === (sb[i*NPORTS+j].size() != 0), $sformatf("i%0d p%0d tx_tvalid", i, j),
                    128'(txv[i][j]), 128'(sb[i*NPORTS+j].size() != 0));
`ifdef ETHSIM_BRIDGE_STATS_EN
                chk(sf[i][j*32 +: 32] === m_frames[i*NPORTS+j], $sformatf("i%0d p%0d stat_frames", i, j),
                    128'(sf[i][j*32 +: 32]), 128'(m_frames[i*NPORTS+j]));
                chk(se[i][j*32 +: 32] === m_errs[i*NPORTS+j], $sformatf("i%0d p%0d stat_errs", i, j),
                    128'(se[i][j*32 +: 32]), 128'(m_errs[i*NPORTS+j]));
`endif
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < NPORTS; j++) begin
                acc[i*NPORTS+j] = rxv[i][j] && exp_rdy[i*NPORTS+j];
                if (acc[i*NPORTS+j]) sb[i*NPORTS+dst(i, j)].push_back(rx_beat(i, j));
`ifdef ETHSIM_BRIDGE_STATS_EN
                if (rst) begin
                    m_frames[i*NPORTS+j] = '0;
                    m_errs[i*NPORTS+j]   = '0;
                end else if (acc[i*NPORTS+j] && rxl[i][j]) begin
                    m_frames[i*NPORTS+j] = m_frames[i*NPORTS+j] + 32'd1;
                    if (rxu[i][j]) m_errs[i*NPORTS+j] = m_errs[i*NPORTS+j] + 32'd1;
                end
`endif
            end
        end
    end

    // Monitor: whatever a tx port presents must be the oldest expected beat for it.
    always @(negedge clk156) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (txv[i][p] === 1'b1) begin
                    chk(sb[i*NPORTS+p].size() != 0, $sformatf("i%0d p%0d tx_spurious", i, p),
                        128'(tx_beat(i, p)), 128'(0));
                    if (sb[i*NPORTS+p].size() != 0) begin
                        chk(tx_beat(i, p) === sb[i*NPORTS+p][0], $sformatf("i%0d p%0d tx_beat", i, p),
                            128'(tx_beat(i, p)), 128'(sb[i*NPORTS+p][0]));
                        if (txr[i][p] && !rst) void'(sb[i*NPORTS+p].pop_front());
                    end
                end
            end
        end
        if (rst) begin
            for (int k = 0; k < NL; k++) sb[k].delete();
        end
    end

    // Driver: offer queued beats, holding each until accepted; random tx_tready.
    initial begin
        beat_t b;
        forever begin
            @(posedge clk156);
            #1;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < NPORTS; j++) begin
                    if (acc[i*NPORTS+j]) begin
                        void'(src[i*NPORTS+j].pop_front());
                        rxv[i][j] = 1'b0;
                    end
                    if (!rxv[i][j]) begin
                        if (src[i*NPORTS+j].size() != 0 && $urandom_range(0, 99) < vprob) begin
                            b = src[i*NPORTS+j][0];
                            rxv[i][j] = 1'b1;
                            rxd[i][j*DATA_W +: DATA_W] = b.data;
                            rxk[i][j*KEEP_W +: KEEP_W] = b.keep;
                            rxl[i][j] = b.last;
                            rxu[i][j] = b.user;
                        end
                    end
                    txr[i][j] = !hold_lo[i][j] && ($urandom_range(0, 99) < rprob);
                end
            end
        end
    end

    task automatic queue_beat(input int k, input logic [63:0] d, input logic [7:0] kp, input bit l, input bit u);
        beat_t b;
        b.data = d;
        b.keep = kp;
        b.last = l;
        b.user = u;
        src[k].push_back(b);
    endtask

    task automatic queue_random(input int k, input int unsigned n);
        bit l;
        for (int unsigned m = 0; m < n; m++) begin
            l = (m == n - 1) || ($urandom_range(0, 3) == 0);
            queue_beat(k, {$urandom, $urandom}, 8'($urandom), l, l && ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!idle() && n < limit) begin
            @(posedge clk156);
            n++;
        end
        chk(idle(), "drain_timeout", 128'(n), 128'(limit));
        repeat (2) @(posedge clk156);
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1;
        vprob = 100;
        rprob = 100;
        for (int i = 0; i < 2; i++) begin
            rxv[i] = '0; rxd[i] = '0; rxk[i] = '0; rxl[i] = '0; rxu[i] = '0;
            txr[i] = '0; hold_lo[i] = '0;
        end
        for (int k = 0; k < NL; k++) acc[k] = 1'b0;
`ifdef ETHSIM_BRIDGE_STATS_EN
        for (int k = 0; k < NL; k++) begin
            m_frames[k] = '0;
            m_errs[k]   = '0;
        end
`endif
        repeat (3) @(posedge clk156);
        #1;
        rst = 1'b0;

        // Loopback: 3-beat frame on port 2, last beat keep 0x0F.
        queue_beat(2, 64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
        queue_beat(2, 64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        queue_beat(2, 64'h3333_3333_3333_3333, 8'h0F, 1'b1, 1'b0);
        wait_idle(200);

        // Pair swap: simultaneous frames on rx 0 and rx 1.
        queue_random(NPORTS + 0, 3);
        queue_random(NPORTS + 1, 3);
        wait_idle(200);

        // Fill lane 0 against a stalled tx, then drain.
        hold_lo[0][0] = 1'b1;
        queue_random(0, 12);
        repeat (14) @(posedge clk156);
        @(negedge clk156);
        #1;
        chk(rxr[0][0] === 1'b0, "full_rx_tready", 128'(rxr[0][0]), 128'(0));
        chk(txv[0][0] === 1'b1, "full_tx_tvalid", 128'(txv[0][0]), 128'(1));
        hold_lo[0][0] = 1'b0;
        wait_idle(200);

        // Random valid/ready on every port of both instances.
        vprob = 70;
        rprob = 60;
        for (int k = 0; k < NL; k++) queue_random(k, 2500);
        wait_idle(40000);

        // Reset with 5 beats buffered in lane 1.
        vprob = 100;
        rprob = 100;
        hold_lo[0] = '1;
        hold_lo[1] = '1;
        queue_random(1, 5);
        n = 0;
        while (sb[1].size() != 5 && n < 50) begin
            @(posedge clk156);
            n++;
        end
        chk(sb[1].size() == 5, "rst_prefill", 128'(sb[1].size()), 128'(5));
        @(posedge clk156);
        #1;
        rst = 1'b1;
        @(posedge clk156);
        #1;
        rst = 1'b0;
        @(negedge clk156);
        #1;
        chk(txv[0][1] === 1'b0, "rst_flush_tx_tvalid", 128'(txv[0][1]), 128'(0));
        chk(rxr[0][1] === 1'b1, "rst_release_rx_tready", 128'(rxr[0][1]), 128'(1));
        hold_lo[0] = '0;
        hold_lo[1] = '0;
        wait_idle(200);

`ifdef ETHSIM_BRIDGE_STATS_EN
        // Three frames on port 3, the second flagged bad on its last beat.
        for (int f = 0; f < 3; f++) begin
            queue_beat(3, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
            queue_beat(3, {$urandom, $urandom}, 8'hFF, 1'b1, f == 1);
        end
        wait_idle(200);
        @(negedge clk156);
        #1;
        chk(sf[0][3*32 +: 32] === 32'd3, "stat_frames_p3", 128'(sf[0][3*32 +: 32]), 128'(3));
        chk(se[0][3*32 +: 32] === 32'd1, "stat_errs_p3", 128'(se[0][3*32 +: 32]), 128'(1));
`endif

        for (int k = 0; k < NL; k++) begin
            chk(sb[k].size() == 0, $sformatf("lane%0d leftover", k), 128'(sb[k].size()), 128'(0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
